multi_ch_sync_fifo: RTL and testbench
=====================================

Name: multi_ch_sync_fifo

Overview:
Single-clock FIFO bank holding NUM_CH independent queues in one shared memory, with one write port and one read port per cycle, each steered by a channel index. It is the parametrised successor to the team's dual-clock FIFO, for same-domain buffering where several streams share one RAM. It adds the following per channel:
- exact occupancy count
- threshold flags
- flush
- sticky overflow/underflow error bits

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 16, entries per channel; power of 2, >= 2.
NUM_CH, 4, number of channels; >= 1.
ALMOST_FULL, 12, almost_full[c] asserted when level >= ALMOST_FULL; range 1..DEPTH.
ALMOST_EMPTY, 4, almost_empty[c] asserted when level <= ALMOST_EMPTY; range 0..DEPTH-1.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous, active-low reset.
w_en  in  1  write request.
w_ch  in  CHW  write channel index; CHW = max(1, clog2(NUM_CH)).
i_dat  in  WIDTH  write data.
r_en  in  1  read (pop) request.
r_ch  in  CHW  read channel index.
o_dat  out  WIDTH  head word of channel r_ch (first-word fall-through).
full  out  NUM_CH  per-channel full.
almost_full  out  NUM_CH  per-channel level >= ALMOST_FULL.
empty  out  NUM_CH  per-channel empty.
almost_empty  out  NUM_CH  per-channel level <= ALMOST_EMPTY.
level  out  NUM_CH*LW  packed per-channel occupancy, channel c at [c*LW +: LW]; LW = clog2(DEPTH)+1.
flush  in  NUM_CH  per-channel synchronous flush.
err_clr  in  NUM_CH  per-channel clear of sticky errors.
ovf  out  NUM_CH  sticky: write attempted while full.
udf  out  NUM_CH  sticky: read attempted while empty.

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low.
- On rst_n=0 at a rising edge, every channel resets to:
  - rd/wr pointers = 0, level = 0
  - empty = 1, full = 0
  - almost_empty = 1, almost_full = 0 (when ALMOST_FULL > 0)
  - ovf = 0, udf = 0
- Memory contents are not reset.
- Reset mid-operation discards all queued data. No partial state survives.
- Memory: NUM_CH*DEPTH words, addressed {ch, ptr[clog2(DEPTH)-1:0]}. Each channel has its own binary wr/rd pointers and level register.
- Write accept: w_en && w_ch < NUM_CH && !full[w_ch] && !flush[w_ch]. When accepted:
  - word stored at that channel's wr pointer
  - wr pointer increments modulo DEPTH
- Read accept: r_en && r_ch < NUM_CH && !empty[r_ch] && !flush[r_ch]. When accepted, rd pointer increments modulo DEPTH.
- o_dat = mem[{r_ch, rdptr[r_ch]}], combinational from r_ch and registered state. It is undefined when empty[r_ch]=1.
- Latency: a word accepted at edge N makes empty[c]=0 and is visible on o_dat from edge N onward. The fall-through latency is 1 cycle.
- Flags are decoded from the level register only: full = (level==DEPTH), empty = (level==0).
- Level update per edge:
  - +1 on write accept only
  - -1 on read accept only
  - unchanged when both accept on the same channel
  - independent when read and write target different channels
- Simultaneous read and write, same channel:
  - Full channel: the write is rejected even though a read is accepted; ovf is set. Level becomes DEPTH-1.
  - Empty channel: the read is rejected even though a write is accepted; udf is set. Level becomes 1.
- Channel index >= NUM_CH (non-power-of-2 NUM_CH): the request is ignored and no flag changes.
- Flush[c]:
  - At the edge: pointers and level of c go to 0; empty=1, almost_empty=1.
  - A same-cycle write or read on c is dropped without setting ovf/udf.
  - Other channels are unaffected.
- ovf[c] is set on a rejected write to a full c; udf[c] is set on a rejected read of an empty c.
- err_clr[c]:
  - clears ovf[c] and udf[c]
  - when a set event and err_clr coincide, the set wins
- Wrap-around: pointers wrap silently. Level never exceeds DEPTH or underflows.

Decomposition:
- Package multi_ch_fifo_pkg holds:
  - CHW and LW derivation functions
  - the packed-level slice helper
  - a reset-value constant for the per-channel flag vector
- Sub-module fifo_ch_ctrl, one per channel via generate, holds:
  - wr/rd pointers, level and the four flags
  - ovf/udf
  - flush/err_clr handling
- fifo_ch_ctrl takes wr_req/rd_req already decoded for its channel.
- The top level owns the shared memory, the channel decode and the o_dat mux.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> all empty=1, full=0, level=0, almost_empty=1, almost_full=0, ovf=udf=0.
- Fill channel 2 with 0x01..0x10 (16 writes) -> level[2] increments 1..16:
  - almost_full[2] rises after the 12th write; full[2] after the 16th
  - a 17th write sets ovf[2]=1 and leaves the data intact
  - draining returns 0x01..0x10 in order on o_dat
- Full channel 0 with simultaneous w_en/r_en on ch0 -> level 16->15, write dropped, ovf[0]=1. On empty ch1 with simultaneous w_en/r_en -> level 0->1, udf[1]=1; o_dat shows the new word next cycle.
- Interleaved writes to ch0/ch3 and reads of ch1/ch3 for 200 random cycles, with a scoreboard per channel -> no cross-channel corruption; the level matches the model every cycle.
- Flush[1] asserted while level[1]=9 with a same-cycle write to ch1 -> level[1]=0, empty[1]=1, no ovf; other channels' levels unchanged.
- Assert rst_n=0 mid-burst with 5 words in ch3 -> next cycle level[3]=0, empty[3]=1; a subsequent write of 0xAA reads back 0xAA.

Source files
------------

// File: rtl/multi_ch_fifo_pkg.sv
// Shared types and width helpers for the multi-channel single-clock FIFO bank.
package multi_ch_fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } ch_flags_t;

  // An idle channel is empty and therefore also almost empty.
  localparam ch_flags_t CH_FLAGS_RST = '{full: 1'b0, almost_full: 1'b0,
                                         empty: 1'b1, almost_empty: 1'b1};

  function automatic int calc_chw(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int calc_lw(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int level_lsb(input int ch, input int lw);
    return ch * lw;
  endfunction

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Per-channel bookkeeping: pointers, occupancy, threshold flags and sticky errors.
module fifo_ch_ctrl
  import multi_ch_fifo_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int ALMOST_FULL  = 12,
  parameter  int ALMOST_EMPTY = 4,
  localparam int AW           = $clog2(DEPTH),
  localparam int LW           = calc_lw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic          rd_req,
  input  logic          flush,
  input  logic          err_clr,
  output logic          wr_acc,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [LW-1:0] level,
  output ch_flags_t     flags,
  output logic          ovf,
  output logic          udf
);

  logic          rd_acc;
  logic          ovf_set;
  logic          udf_set;
  logic [LW-1:0] level_nxt;

  function automatic ch_flags_t decode(input logic [LW-1:0] lv);
    ch_flags_t f;
    f.full         = (lv == LW'(DEPTH));
    f.almost_full  = (lv >= LW'(ALMOST_FULL));
    f.empty        = (lv == '0);
    f.almost_empty = (lv <= LW'(ALMOST_EMPTY));
    return f;
  endfunction

  // Flags come from the pre-edge level, so a full channel refuses a write even
  // when a read on the same edge frees a slot (and likewise for empty).
  always_comb begin
    wr_acc    = wr_req && !flags.full && !flush;
    rd_acc    = rd_req && !flags.empty && !flush;
    ovf_set   = wr_req && flags.full && !flush;
    udf_set   = rd_req && flags.empty && !flush;
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (wr_acc && !rd_acc)
      level_nxt = level + 1'b1;
    else if (rd_acc && !wr_acc)
      level_nxt = level - 1'b1;
  end

  // Flags are registered from the next level so they always equal decode(level).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      flags  <= CH_FLAGS_RST;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_nxt;
      flags <= decode(level_nxt);
      ovf   <= ovf_set | (ovf & ~err_clr);
      udf   <= udf_set | (udf & ~err_clr);
    end
  end

endmodule

// File: rtl/multi_ch_sync_fifo.sv
// NUM_CH independent FIFOs sharing one memory, with one write and one read port per cycle.
module multi_ch_sync_fifo
  import multi_ch_fifo_pkg::*;
#(
  parameter  int WIDTH        = 8,
  parameter  int DEPTH        = 16,
  parameter  int NUM_CH       = 4,
  parameter  int ALMOST_FULL  = 12,
  parameter  int ALMOST_EMPTY = 4,
  localparam int CHW          = calc_chw(NUM_CH),
  localparam int LW           = calc_lw(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_en,
  input  logic [CHW-1:0]       w_ch,
  input  logic [WIDTH-1:0]     i_dat,
  input  logic                 r_en,
  input  logic [CHW-1:0]       r_ch,
  output logic [WIDTH-1:0]     o_dat,
  output logic [NUM_CH-1:0]    full,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [NUM_CH-1:0]    empty,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH*LW-1:0] level,
  input  logic [NUM_CH-1:0]    flush,
  input  logic [NUM_CH-1:0]    err_clr,
  output logic [NUM_CH-1:0]    ovf,
  output logic [NUM_CH-1:0]    udf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [NUM_CH*DEPTH];
  logic [AW-1:0]      wr_ptr [NUM_CH];
  logic [AW-1:0]      rd_ptr [NUM_CH];
  logic [NUM_CH-1:0]  wr_req;
  logic [NUM_CH-1:0]  rd_req;
  logic [NUM_CH-1:0]  wr_acc;
  logic [CHW+AW-1:0]  wr_addr;
  logic [CHW+AW-1:0]  rd_addr;

  // Exact-match decode: an index beyond NUM_CH selects no channel and is ignored.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ch_flags_t     flags_c;
    logic [LW-1:0] level_c;

    assign wr_req[c] = w_en && (w_ch == CHW'(c));
    assign rd_req[c] = r_en && (r_ch == CHW'(c));

    fifo_ch_ctrl #(
      .DEPTH       (DEPTH),
      .ALMOST_FULL (ALMOST_FULL),
      .ALMOST_EMPTY(ALMOST_EMPTY)
    ) u_ctrl (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_req (wr_req[c]),
      .rd_req (rd_req[c]),
      .flush  (flush[c]),
      .err_clr(err_clr[c]),
      .wr_acc (wr_acc[c]),
      .wr_ptr (wr_ptr[c]),
      .rd_ptr (rd_ptr[c]),
      .level  (level_c),
      .flags  (flags_c),
      .ovf    (ovf[c]),
      .udf    (udf[c])
    );

    assign full[c]         = flags_c.full;
    assign almost_full[c]  = flags_c.almost_full;
    assign empty[c]        = flags_c.empty;
    assign almost_empty[c] = flags_c.almost_empty;
    assign level[level_lsb(c, LW) +: LW] = level_c;
  end

  always_comb begin
    wr_addr = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (wr_acc[c]) wr_addr = {CHW'(c), wr_ptr[c]};
  end

  always_comb begin
    rd_addr = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (r_ch == CHW'(c)) rd_addr = {CHW'(c), rd_ptr[c]};
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (|wr_acc) mem[wr_addr] <= i_dat;
  end

  assign o_dat = mem[rd_addr];

endmodule

// File: tb/tb_multi_ch_sync_fifo.sv
// Scoreboard bench for multi_ch_sync_fifo against a queue-per-channel reference model.
module tb_multi_ch_sync_fifo;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int AF     = 12;
  localparam int AE     = 4;
  localparam int LW     = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 w_en;
  logic [1:0]           w_ch;
  logic [WIDTH-1:0]     i_dat;
  logic                 r_en;
  logic [1:0]           r_ch;
  logic [WIDTH-1:0]     o_dat;
  logic [NUM_CH-1:0]    full, almost_full, empty, almost_empty;
  logic [NUM_CH*LW-1:0] level;
  logic [NUM_CH-1:0]    flush, err_clr, ovf, udf;

  logic [WIDTH-1:0]  mq [NUM_CH][$];
  logic [WIDTH-1:0]  exp_q [$];
  logic [NUM_CH-1:0] ovf_m, udf_m;
  int checks = 0;
  int errors = 0;

  multi_ch_sync_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
    .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_ch(w_ch), .i_dat(i_dat),
    .r_en(r_en), .r_ch(r_ch), .o_dat(o_dat), .full(full),
    .almost_full(almost_full), .empty(empty), .almost_empty(almost_empty),
    .level(level), .flush(flush), .err_clr(err_clr), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model to its post-edge state.
  task automatic applyStimulus(input logic rst, input logic we, input logic [1:0] wc,
                               input logic [7:0] wd, input logic re, input logic [1:0] rc,
                               input logic [3:0] fl, input logic [3:0] ec);
    bit w, r, os, us;
    int sz;
    rst_n = rst; w_en = we; w_ch = wc; i_dat = wd;
    r_en = re; r_ch = rc; flush = fl; err_clr = ec;
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      ovf_m = '0;
      udf_m = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        w  = we && (int'(wc) == c);
        r  = re && (int'(rc) == c);
        sz = mq[c].size();
        os = 1'b0;
        us = 1'b0;
        if (fl[c]) begin
          mq[c].delete();
        end else begin
          if (r) begin
            if (sz == 0) us = 1'b1;
            else exp_q.push_back(mq[c].pop_front());
          end
          if (w) begin
            if (sz == DEPTH) os = 1'b1;
            else mq[c].push_back(wd);
          end
        end
        ovf_m[c] = os | (ovf_m[c] & ~ec[c]);
        udf_m[c] = us | (udf_m[c] & ~ec[c]);
      end
    end
  endtask

  task automatic checkOutput();
    logic [NUM_CH*LW-1:0] lv;
    logic [NUM_CH-1:0]    f, af, e, ae;
    for (int c = 0; c < NUM_CH; c++) begin
      lv[c*LW +: LW] = LW'(mq[c].size());
      f[c]  = (mq[c].size() == DEPTH);
      af[c] = (mq[c].size() >= AF);
      e[c]  = (mq[c].size() == 0);
      ae[c] = (mq[c].size() <= AE);
    end
    checkVal("level", 32'(level), 32'(lv));
    checkVal("full", 32'(full), 32'(f));
    checkVal("almost_full", 32'(almost_full), 32'(af));
    checkVal("empty", 32'(empty), 32'(e));
    checkVal("almost_empty", 32'(almost_empty), 32'(ae));
    checkVal("ovf", 32'(ovf), 32'(ovf_m));
    checkVal("udf", 32'(udf), 32'(udf_m));
    if (rst_n && mq[r_ch].size() > 0)
      checkVal("o_dat_head", 32'(o_dat), 32'(mq[r_ch][0]));
  endtask

  task automatic step(input logic rst, input logic we, input logic [1:0] wc,
                      input logic [7:0] wd, input logic re, input logic [1:0] rc,
                      input logic [3:0] fl, input logic [3:0] ec);
    applyStimulus(rst, we, wc, wd, re, rc, fl, ec);
    @(negedge clk);
    checkOutput();
  endtask

  // Monitor: whenever the DUT is about to accept a pop, its head word must match the scoreboard.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n === 1'b1 && r_en === 1'b1 && empty[r_ch] === 1'b0 && flush[r_ch] === 1'b0) begin
        if (exp_q.size() == 0) begin
          checkVal("unexpected_pop", 32'(o_dat), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkVal("pop_data", 32'(o_dat), 32'(e));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; w_en = 1'b0; w_ch = '0; i_dat = '0;
    r_en = 1'b0; r_ch = '0; flush = '0; err_clr = '0;
    ovf_m = '0; udf_m = '0;
    @(negedge clk);

    $display("[TB] reset");
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] fill, overflow and drain channel 2");
    for (int i = 1; i <= DEPTH; i++) step(1, 1, 2, 8'(i), 0, 0, 0, 0);
    step(1, 1, 2, 8'h55, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 1, 2, 0, 0);
    step(1, 0, 0, 0, 0, 2, 0, 4'hF);

    $display("[TB] simultaneous read/write on full ch0 and empty ch1");
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 8'($urandom), 0, 0, 0, 0);
    step(1, 1, 0, 8'h77, 1, 0, 0, 0);
    step(1, 1, 1, 8'h3C, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 4'hF);

    $display("[TB] random interleave");
    for (int i = 0; i < 200; i++)
      step(1, 1'($urandom), ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 8'($urandom),
           1'($urandom), ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd1, 4'h0,
           ($urandom_range(0, 15) == 0) ? 4'hF : 4'h0);
    step(1, 0, 0, 0, 0, 0, 0, 4'hF);

    $display("[TB] flush ch1 with same-cycle write");
    step(1, 0, 0, 0, 0, 0, 4'b0010, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 1, 8'($urandom), 0, 0, 0, 0);
    step(1, 1, 1, 8'hEE, 0, 0, 4'b0010, 0);

    $display("[TB] reset mid-burst");
    step(1, 0, 0, 0, 0, 0, 4'b1000, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 3, 8'($urandom), 0, 0, 0, 0);
    step(0, 1, 3, 8'h99, 1, 3, 0, 0);
    step(1, 1, 3, 8'hAA, 0, 3, 0, 0);
    step(1, 0, 0, 0, 1, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    checkVal("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
